// File: rtl/rv32i_io_param.sv
// rv32i_io_param: memory-mapped IO space with debounced keys, sticky key edges, a match timer and a registered irq.
module rv32i_io_param #(
    parameter int          NUM_KEYS        = 2,
    parameter int          NUM_LEDS        = 10,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] IO_BASE         = 32'hFFFF_FF00
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                io_we,
    input  logic [3:0]          io_be,
    input  logic [29:0]         io_addr,
    input  logic [31:0]         io_wdata,
    output logic [31:0]         io_rdata,
    output logic [NUM_LEDS-1:0] led,
    output logic                irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic                sel, wr_en;
    logic [5:0]          off;
    logic [31:0]         wmask, wbits, rd_nxt, t_count, t_cmp;
    logic [NUM_KEYS-1:0] sync1, sync2, raw, key_state, state_nxt, key_edge, key_ie, edge_clr;
    logic [CW-1:0]       cnt [NUM_KEYS];
    logic [CW-1:0]       cnt_nxt [NUM_KEYS];
    logic                t_match, t_en, t_ie, match_clr;

    assign sel       = io_addr[29:6] == IO_BASE[31:8];
    assign off       = io_addr[5:0];
    assign wr_en     = io_we && sel;
    assign wmask     = {{8{io_be[3]}}, {8{io_be[2]}}, {8{io_be[1]}}, {8{io_be[0]}}};
    assign wbits     = io_wdata & wmask;
    assign raw       = ~sync2;
    assign edge_clr  = (wr_en && off == 6'd2) ? wbits[NUM_KEYS-1:0] : '0;
    assign match_clr = wr_en && off == 6'd5 && wbits[0];

    // A key must disagree with its accepted state for DEBOUNCE_CYCLES straight cycles to flip it.
    always_comb begin
        state_nxt = key_state;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_nxt[i]   = (raw[i] != key_state[i] && cnt[i] != CW'(DEBOUNCE_CYCLES - 1)) ? cnt[i] + CW'(1) : '0;
            state_nxt[i] = (raw[i] != key_state[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) ? raw[i] : key_state[i];
        end
    end

    always_comb begin
        rd_nxt = '0;
        if (sel)
            case (off)
                6'd0:    rd_nxt = 32'(led);
                6'd1:    rd_nxt = 32'(key_state);
                6'd2:    rd_nxt = 32'(key_edge);
                6'd3:    rd_nxt = t_count;
                6'd4:    rd_nxt = t_cmp;
                6'd5:    rd_nxt = {29'b0, t_ie, t_en, t_match};
                6'd6:    rd_nxt = 32'(key_ie);
                default: rd_nxt = '0;
            endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= '1;
            sync2     <= '1;
            key_state <= '0;
            key_edge  <= '0;
            key_ie    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
            led       <= '0;
            t_count   <= '0;
            t_cmp     <= '0;
            t_match   <= 1'b0;
            t_en      <= 1'b0;
            t_ie      <= 1'b0;
            irq       <= 1'b0;
            io_rdata  <= '0;
        end else begin
            sync1     <= key;
            sync2     <= sync1;
            key_state <= state_nxt;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= cnt_nxt[i];
            key_edge  <= (key_edge & ~edge_clr) | (state_nxt & ~key_state);
            if (wr_en && off == 6'd0) led <= (led & ~wmask[NUM_LEDS-1:0]) | wbits[NUM_LEDS-1:0];
            if (wr_en && off == 6'd6) key_ie <= (key_ie & ~wmask[NUM_KEYS-1:0]) | wbits[NUM_KEYS-1:0];
            if (wr_en && off == 6'd4) t_cmp <= (t_cmp & ~wmask) | wbits;
            t_count   <= (wr_en && off == 6'd3) ? (t_count & ~wmask) | wbits : t_count + 32'(t_en);
            t_match   <= (t_en && t_count == t_cmp) | (t_match & ~match_clr);
            if (wr_en && off == 6'd5 && io_be[0]) begin
                t_en <= io_wdata[1];
                t_ie <= io_wdata[2];
            end
            irq       <= |(key_edge & key_ie) | (t_match & t_ie);
            io_rdata  <= rd_nxt;
        end
    end
endmodule

// File: tb/tb_rv32i_io_param.sv
// tb_rv32i_io_param: scoreboard bench for rv32i_io_param with a cycle-level register-map model.
module tb_rv32i_io_param;
    localparam int DC = 4;
    localparam logic [29:0] BASE = 30'h3FFF_FFC0;

    logic        clk = 0, reset = 0, io_we = 0, irq;
    logic [1:0]  key = 2'b11;
    logic [3:0]  io_be = 0;
    logic [29:0] io_addr = 0;
    logic [31:0] io_wdata = 0, io_rdata;
    logic [9:0]  led;

    rv32i_io_param #(.NUM_KEYS(2), .NUM_LEDS(10), .DEBOUNCE_CYCLES(DC), .IO_BASE(32'hFFFF_FF00)) dut (
        .clk(clk), .reset(reset), .key(key), .io_we(io_we), .io_be(io_be), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .led(led), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int kind; logic [31:0] exp; string name; } ent_t;
    ent_t sb[$];
    ent_t e;
    int cyc_n = 0, n_tests = 0, n_fail = 0;
    bit done = 0;
    logic [31:0] act;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc_n) begin
            e = sb.pop_front();
            act = e.kind == 0 ? io_rdata : e.kind == 1 ? 32'(led) : 32'(irq);
            n_tests++;
            if (e.cyc != cyc_n || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc_n, act, e.exp);
            end
        end
        if (done) begin
            if (sb.size() != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_drain left=%0d expected=0", sb.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    // Reference model: architectural registers plus the two-sample key delay and stable-run counts.
    logic [31:0] m_led, m_ie, m_edge, m_state, m_cnt, m_cmp, m_rdata;
    logic        m_match, m_en, m_mie, m_irq;
    logic [1:0]  m_s1, m_s2;
    int          m_run [2];

    function automatic logic [31:0] expand(logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    function automatic logic [31:0] mread(logic [29:0] a);
        if (a[29:6] != 24'hFF_FFFF) return 32'h0;
        case (a[5:0])
            6'd0: return m_led;
            6'd1: return m_state;
            6'd2: return m_edge;
            6'd3: return m_cnt;
            6'd4: return m_cmp;
            6'd5: return {29'b0, m_mie, m_en, m_match};
            6'd6: return m_ie;
            default: return 32'h0;
        endcase
    endfunction

    task automatic mreset();
        {m_led, m_ie, m_edge, m_state, m_cnt, m_cmp, m_rdata} = '0;
        {m_match, m_en, m_mie, m_irq} = '0;
        m_s1 = 2'b11;
        m_s2 = 2'b11;
        m_run[0] = 0;
        m_run[1] = 0;
    endtask

    task automatic mstep(input logic we, input logic [3:0] be, input logic [29:0] a,
                         input logic [31:0] wd, input logic [1:0] kv);
        logic [31:0] m, w, rise;
        logic [1:0]  raw, ns;
        logic        hit, nm, irq_n;
        logic [5:0]  o;
        m = expand(be);
        w = wd & m;
        hit = we && a[29:6] == 24'hFF_FFFF;
        o = a[5:0];
        m_rdata = mread(a);
        raw = ~m_s2;
        ns = m_state[1:0];
        for (int k = 0; k < 2; k++) begin
            if (raw[k] != ns[k]) begin
                m_run[k]++;
                if (m_run[k] == DC) begin
                    ns[k] = raw[k];
                    m_run[k] = 0;
                end
            end else m_run[k] = 0;
        end
        rise = {30'b0, ns & ~m_state[1:0]};
        irq_n = |(m_edge & m_ie) | (m_match & m_mie);
        nm = m_en && m_cnt == m_cmp;
        m_cnt = (hit && o == 3) ? (m_cnt & ~m) | w : m_cnt + (m_en ? 32'd1 : 32'd0);
        if (hit && o == 0) m_led = ((m_led & ~m) | w) & 32'h3FF;
        if (hit && o == 4) m_cmp = (m_cmp & ~m) | w;
        if (hit && o == 6) m_ie = ((m_ie & ~m) | w) & 32'h3;
        m_edge = (m_edge & ~((hit && o == 2) ? w : 32'h0)) | rise;
        m_match = nm | (m_match & !(hit && o == 5 && w[0]));
        if (hit && o == 5 && be[0]) begin
            m_en = wd[1];
            m_mie = wd[2];
        end
        m_state = {30'b0, ns};
        m_s2 = m_s1;
        m_s1 = kv;
        m_irq = irq_n;
    endtask

    task automatic push(int c, int k, logic [31:0] v, string nm);
        ent_t t;
        t.cyc = c;
        t.kind = k;
        t.exp = v;
        t.name = nm;
        sb.push_back(t);
    endtask

    task automatic expc(int k, logic [31:0] v, string nm);
        push(cyc_n + 1, k, v, nm);
    endtask

    task automatic step(input logic we, input logic [3:0] be, input logic [29:0] a, input logic [31:0] wd);
        io_we = we;
        io_be = be;
        io_addr = a;
        io_wdata = wd;
        mstep(we, be, a, wd, key);
        push(cyc_n + 1, 0, m_rdata, "rdata");
        push(cyc_n + 1, 1, m_led, "led");
        push(cyc_n + 1, 2, {31'b0, m_irq}, "irq");
        @(negedge clk);
    endtask

    task automatic wr(int o, logic [3:0] be, logic [31:0] d);
        step(1'b1, be, BASE | 30'(o), d);
    endtask

    task automatic rd(int o);
        step(1'b0, 4'h0, BASE | 30'(o), 32'h0);
    endtask

    task automatic idle(int n);
        repeat (n) rd(0);
    endtask

    // Reset is raised just after a rising edge and checked before the next one, so only an asynchronous clear passes.
    task automatic do_reset();
        io_we = 0;
        @(posedge clk);
        #1 reset = 0;
        mreset();
        push(cyc_n, 0, 32'h0, "rst_rdata");
        push(cyc_n, 1, 32'h0, "rst_led");
        push(cyc_n, 2, 32'h0, "rst_irq");
        @(negedge clk);
        push(cyc_n + 1, 0, 32'h0, "rst_hold_rdata");
        push(cyc_n + 1, 1, 32'h0, "rst_hold_led");
        @(negedge clk);
        #1 reset = 1;
    endtask

    initial begin
        logic        we;
        logic [3:0]  be;
        logic [29:0] a;
        logic [31:0] wd;
        int          o;
        mreset();
        do_reset();
        wr(0, 4'b1111, 32'h0000_03A5);
        expc(0, 32'h3A5, "led_rd");
        expc(1, 32'h3A5, "led_out");
        rd(0);
        wr(0, 4'b0010, 32'hFFFF_FFFF);
        expc(0, 32'h3A5, "led_be");
        rd(0);
        key = 2'b10;
        idle(3);
        key = 2'b11;
        idle(6);
        expc(0, 32'h0, "glitch_state");
        rd(1);
        expc(0, 32'h0, "glitch_edge");
        rd(2);
        key = 2'b10;
        idle(10);
        expc(0, 32'h1, "press_state");
        rd(1);
        expc(0, 32'h1, "press_edge");
        rd(2);
        wr(2, 4'b1110, 32'hFFFF_FFFF);
        expc(0, 32'h1, "w1c_lane_off");
        rd(2);
        wr(2, 4'b0001, 32'h1);
        expc(0, 32'h0, "w1c_clear");
        rd(2);
        wr(6, 4'b1111, 32'h1);
        key = 2'b11;
        idle(8);
        key = 2'b10;
        idle(8);
        expc(0, 32'h1, "edge_set");
        expc(2, 32'h1, "irq_key");
        rd(2);
        key = 2'b11;
        idle(8);
        key = 2'b10;
        idle(5);
        wr(2, 4'b0001, 32'h1);
        expc(0, 32'h1, "edge_race");
        expc(2, 32'h1, "irq_race");
        rd(2);
        wr(6, 4'b1111, 32'h0);
        wr(2, 4'b1111, 32'hFFFF_FFFF);
        wr(3, 4'b1111, 32'hFFFF_FFFE);
        wr(4, 4'b1111, 32'h0000_0001);
        wr(5, 4'b0001, 32'h6);
        idle(6);
        expc(0, 32'h7, "ctrl_match");
        expc(2, 32'h1, "irq_timer");
        rd(5);
        wr(5, 4'b0001, 32'h7);
        idle(1);
        expc(0, 32'h6, "ctrl_w1c");
        expc(2, 32'h0, "irq_drop");
        rd(5);
        wr(3, 4'b1111, 32'h10);
        expc(0, 32'h10, "count_wr");
        rd(3);
        expc(0, 32'h11, "count_inc");
        rd(3);
        expc(0, 32'h0, "unmapped");
        rd(7);
        expc(0, 32'h0, "outside");
        step(1'b0, 4'h0, 30'h0000_0100, 32'h0);
        key = 2'b11;
        idle(8);
        key = 2'b10;
        idle(3);
        do_reset();
        expc(0, 32'h0, "count_after_rst");
        rd(3);
        idle(2);
        expc(0, 32'h0, "deb_restart");
        rd(1);
        idle(4);
        expc(0, 32'h1, "deb_done");
        rd(1);
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(7) == 0) key[0] = ~key[0];
            if ($urandom_range(7) == 0) key[1] = ~key[1];
            we = $urandom_range(2) == 0;
            be = 4'($urandom);
            o = $urandom_range(7);
            a = ($urandom_range(9) == 0) ? 30'($urandom) : BASE | 30'(o);
            wd = (o == 3 || o == 4) ? 32'($urandom_range(40)) : $urandom;
            step(we, be, a, wd);
        end
        idle(2);
        done = 1;
    end
endmodule
